rf_wport_arbiter: RTL and testbench

Arbiter and sequencer for the single register-file write port. It shares the port between the pipeline write-back stage and a long-latency result source (multi-cycle multiply/divide, miss-returned loads). Write-back always has priority. Long-latency results wait in a small FIFO, and an age counter forces a drain so they cannot starve. A pending-address query lets decode stall on reads and writes to registers whose queued result has not yet committed.

---
 rtl/rf_wport_if.sv | 41 ++++
 rtl/rf_wport_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_if.sv
// Register-file write-port bundle: write-back request, long-latency push,
// pending-address query and the registered write port.
interface rf_wport_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned QDEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  logic              wb_we;
  logic              wb_stall;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              wb_hold;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_hit;
  logic [CNT_W-1:0]  q_count;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Requester / pipeline side
  modport master (
    output wb_we, wb_stall, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data, pend_addr,
    input  lu_ready, wb_hold, pend_hit, q_count,
    input  rf_we, rf_waddr, rf_wdata
  );

  // Arbiter side
  modport slave (
    input  wb_we, wb_stall, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data, pend_addr,
    output lu_ready, wb_hold, pend_hit, q_count,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Single register-file write port shared by write-back (priority) and a
// small FIFO of long-latency results with an anti-starvation forced drain.
module rf_wport_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned QDEPTH       = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic        clk,
  input logic        rstn,
  rf_wport_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [QDEPTH];
  logic [QDEPTH-1:0] vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [AGE_W-1:0]  age;
  logic              hold;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic nonempty, wb_req, ready, push, pop, hold_nxt, hit;

  // Grant decision: a pending forced drain blanks wb_req, so popping
  // whenever the FIFO has data and WB is not requesting covers both pop cases.
  always_comb begin
    nonempty = (count != '0);
    wb_req   = bus.wb_we & ~bus.wb_stall & ~hold & (bus.wb_addr != '0);
    ready    = rstn & (count < CNT_W'(QDEPTH));
    push     = bus.lu_valid & ready & (bus.lu_addr != '0);
    pop      = nonempty & ~wb_req;
    hold_nxt = nonempty & ~pop & (age == AGE_W'(STARVE_LIMIT - 1));
  end

  // Pending-write query over queued entries and the in-flight output write
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (vld[i] && (mem[i].addr == bus.pend_addr)) hit = 1'b1;
    end
    if (rf_we_q && (rf_waddr_q == bus.pend_addr)) hit = 1'b1;
    if (bus.pend_addr == '0) hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: bus.lu_addr, data: bus.lu_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head age and one-cycle forced-drain pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      age  <= '0;
      hold <= 1'b0;
    end else begin
      hold <= hold_nxt;
      if (pop || !nonempty)                      age <= '0;
      else if (age != AGE_W'(STARVE_LIMIT))      age <= age + AGE_W'(1);
    end
  end

  // Registered write port; address/data hold their value when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (pop) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= mem[rd_ptr].addr;
      rf_wdata_q <= mem[rd_ptr].data;
    end else if (wb_req) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= bus.wb_addr;
      rf_wdata_q <= bus.wb_data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign bus.lu_ready = ready;
  assign bus.pend_hit = hit;
  assign bus.q_count  = count;
  assign bus.wb_hold  = hold;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: queue-based reference model compared every
// negedge, directed scenarios with literal expectations, then random traffic.
module tb_rf_wport_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned QD = 2;
  localparam int unsigned SL = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rf_wport_if #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD)) bus ();

  rf_wport_arbiter #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD), .STARVE_LIMIT(SL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of waiting results plus head wait time
  ent_t          mq[$];
  int            m_age = 0;
  bit            m_hold = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  always @(negedge clk) begin
    bit   exp_hit, nonempty, ready, wreq, popped;
    ent_t e;
    if (!rstn) begin
      chk("rst_rf_we",    64'(bus.rf_we), 0);
      chk("rst_rf_waddr", 64'(bus.rf_waddr), 0);
      chk("rst_rf_wdata", 64'(bus.rf_wdata), 0);
      chk("rst_q_count",  64'(bus.q_count), 0);
      chk("rst_wb_hold",  64'(bus.wb_hold), 0);
      chk("rst_lu_ready", 64'(bus.lu_ready), 0);
      chk("rst_pend_hit", 64'(bus.pend_hit), 0);
      mq.delete();
      m_age = 0; m_hold = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      nonempty = (mq.size() > 0);
      ready    = (mq.size() < QD);
      exp_hit  = 0;
      foreach (mq[i]) if (mq[i].addr == bus.pend_addr) exp_hit = 1;
      if (m_we && m_waddr == bus.pend_addr) exp_hit = 1;
      if (bus.pend_addr == 0) exp_hit = 0;

      chk("rf_we",    64'(bus.rf_we), 64'(m_we));
      chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
      chk("q_count",  64'(bus.q_count), 64'(mq.size()));
      chk("wb_hold",  64'(bus.wb_hold), 64'(m_hold));
      chk("lu_ready", 64'(bus.lu_ready), 64'(ready));
      chk("pend_hit", 64'(bus.pend_hit), 64'(exp_hit));

      wreq   = bus.wb_we && !bus.wb_stall && !m_hold && (bus.wb_addr != 0);
      popped = 0;
      if (nonempty && (m_hold || !wreq)) begin
        e = mq.pop_front();
        m_we = 1; m_waddr = e.addr; m_wdata = e.data; popped = 1;
      end else if (wreq) begin
        m_we = 1; m_waddr = bus.wb_addr; m_wdata = bus.wb_data;
      end else begin
        m_we = 0;
      end
      if (bus.lu_valid && ready && bus.lu_addr != 0) mq.push_back('{bus.lu_addr, bus.lu_data});
      m_hold = nonempty && !popped && (m_age == SL - 1);
      if (popped || !nonempty) m_age = 0;
      else if (m_age < SL)     m_age++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we = 0; bus.wb_stall = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.lu_valid = 0; bus.lu_addr = '0; bus.lu_data = '0;
  endtask

  initial begin
    idle();
    bus.pend_addr = '0;
    repeat (3) tick();
    chk("in_reset_lu_ready", 64'(bus.lu_ready), 0);
    rstn = 1'b1;

    // First WB write after reset
    bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    tick();
    chk("wb5_rf_we", 64'(bus.rf_we), 1);
    chk("wb5_rf_waddr", 64'(bus.rf_waddr), 5);
    chk("wb5_rf_wdata", 64'(bus.rf_wdata), 64'h1234);
    chk("wb5_q_count", 64'(bus.q_count), 0);

    // Writes to register 0 from both sources are dropped
    bus.wb_addr = '0; bus.lu_valid = 1; bus.lu_addr = '0; bus.lu_data = 32'h55;
    tick();
    chk("r0_rf_we", 64'(bus.rf_we), 0);
    chk("r0_q_count", 64'(bus.q_count), 0);
    chk("r0_lu_ready", 64'(bus.lu_ready), 1);
    idle();
    tick();

    // Starvation: WB writes every cycle while two results queue up
    bus.wb_we = 1; bus.wb_addr = 5'd10; bus.wb_data = 32'h100;
    bus.lu_valid = 1; bus.lu_addr = 5'd7; bus.lu_data = 32'hA;
    tick();
    bus.lu_addr = 5'd8; bus.lu_data = 32'hB;
    tick();
    bus.lu_valid = 0; bus.pend_addr = 5'd7;
    #1;
    chk("st_q_count", 64'(bus.q_count), 2);
    chk("st_lu_ready", 64'(bus.lu_ready), 0);
    chk("st_pend_hit7", 64'(bus.pend_hit), 1);
    tick();
    tick();
    chk("st_no_hold_yet", 64'(bus.wb_hold), 0);
    tick();
    chk("st_hold", 64'(bus.wb_hold), 1);
    tick();
    chk("st_drain_we", 64'(bus.rf_we), 1);
    chk("st_drain_addr", 64'(bus.rf_waddr), 7);
    chk("st_drain_data", 64'(bus.rf_wdata), 64'hA);
    chk("st_hold_off", 64'(bus.wb_hold), 0);
    chk("st_pend_hit7_out", 64'(bus.pend_hit), 1);
    tick();
    chk("st_pend_hit7_clr", 64'(bus.pend_hit), 0);
    chk("st_wb_after", 64'(bus.rf_waddr), 10);
    idle();
    repeat (3) tick();

    // Full FIFO: push refused on a popping cycle, accepted the next one
    bus.wb_we = 1; bus.wb_addr = 5'd20; bus.wb_data = 32'h200;
    bus.lu_valid = 1; bus.lu_addr = 5'd11; bus.lu_data = 32'h11;
    tick();
    bus.lu_addr = 5'd12; bus.lu_data = 32'h12;
    tick();
    bus.wb_we = 0; bus.lu_addr = 5'd13; bus.lu_data = 32'h13; bus.pend_addr = 5'd13;
    #1;
    chk("full_lu_ready", 64'(bus.lu_ready), 0);
    tick();
    chk("full_q_count_pop", 64'(bus.q_count), 1);
    chk("full_pend13_no", 64'(bus.pend_hit), 0);
    chk("full_ready_again", 64'(bus.lu_ready), 1);
    tick();
    bus.lu_valid = 0;
    #1;
    chk("full_q_count_acc", 64'(bus.q_count), 1);
    chk("full_pend13_yes", 64'(bus.pend_hit), 1);
    idle();
    repeat (3) tick();

    // Stalled WB does not block a queued entry
    bus.lu_valid = 1; bus.lu_addr = 5'd3; bus.lu_data = 32'h33;
    bus.wb_we = 1; bus.wb_stall = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    tick();
    bus.lu_valid = 0;
    tick();
    chk("stall_rf_we", 64'(bus.rf_we), 1);
    chk("stall_rf_waddr", 64'(bus.rf_waddr), 3);
    chk("stall_q_count", 64'(bus.q_count), 0);
    chk("stall_hold", 64'(bus.wb_hold), 0);
    idle();
    repeat (2) tick();

    // Reset with a full FIFO and a write in flight
    bus.wb_we = 1; bus.wb_addr = 5'd21; bus.wb_data = 32'h21;
    bus.lu_valid = 1; bus.lu_addr = 5'd14; bus.lu_data = 32'h14;
    tick();
    bus.lu_addr = 5'd15; bus.lu_data = 32'h15;
    tick();
    idle();
    bus.pend_addr = 5'd14;
    chk("pre_rst_q_count", 64'(bus.q_count), 2);
    chk("pre_rst_rf_we", 64'(bus.rf_we), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rf_we", 64'(bus.rf_we), 0);
    chk("mid_rst_waddr", 64'(bus.rf_waddr), 0);
    chk("mid_rst_q_count", 64'(bus.q_count), 0);
    chk("mid_rst_pend_hit", 64'(bus.pend_hit), 0);
    chk("mid_rst_lu_ready", 64'(bus.lu_ready), 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_q_count", 64'(bus.q_count), 0);
    chk("post_rst_lu_ready", 64'(bus.lu_ready), 1);
    chk("post_rst_pend_hit", 64'(bus.pend_hit), 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.wb_we    = ($urandom_range(0, 9) < 6);
      bus.wb_stall = ($urandom_range(0, 9) < 2);
      bus.wb_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      bus.wb_data  = $urandom;
      bus.lu_valid = ($urandom_range(0, 1) == 1);
      bus.lu_addr  = AW'($urandom_range(0, 15));
      bus.lu_data  = $urandom;
      bus.pend_addr = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) rstn = 1'b0;
      tick();
      rstn = 1'b1;
    end

    idle();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
